// File: rtl/io_output_reg_if.sv
// CPU store/load path and consumer handshake for the memory-mapped output ports.
interface io_output_reg_if;
   localparam int unsigned DW      = 32;
   localparam int unsigned N_PORTS = 3;

   logic [DW-1:0]      addr;
   logic [DW-1:0]      datain;
   logic               write_io_enable;
   logic [DW-1:0]      io_read_data;
   logic [DW-1:0]      out_port0;
   logic [DW-1:0]      out_port1;
   logic [DW-1:0]      out_port2;
   logic [N_PORTS-1:0] out_valid;
   logic [N_PORTS-1:0] out_ack;
   logic [N_PORTS-1:0] overrun;

   modport master (
      output addr, datain, write_io_enable, out_ack,
      input  io_read_data, out_port0, out_port1, out_port2, out_valid, overrun
   );

   modport slave (
      input  addr, datain, write_io_enable, out_ack,
      output io_read_data, out_port0, out_port1, out_port2, out_valid, overrun
   );
endinterface

// File: rtl/io_output_reg.sv
// Three memory-mapped output ports with valid/ack handshake, sticky overrun
// flags and a status word; combinational readback to the CPU load path.
module io_output_reg #(
   parameter logic [5:0]  SEL_BASE = 6'b100000,
   parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
   input logic             io_clk,
   input logic             reset,
   io_output_reg_if.slave  bus
);
   localparam int unsigned DW       = 32;
   localparam int unsigned N_PORTS  = 3;
   localparam int unsigned SEL_W    = 6;
   localparam int unsigned STAT_PAD = DW - 2 * N_PORTS;
   localparam logic [SEL_W-1:0] STATUS_SEL = SEL_BASE + SEL_W'(3);

   logic [SEL_W-1:0]                 sel;
   logic [N_PORTS-1:0]               port_sel;
   logic [N_PORTS-1:0]               port_wr;
   logic                             status_wr;
   logic [N_PORTS-1:0][DW-1:0]       port_q;
   logic [N_PORTS-1:0]               valid_q;
   logic [N_PORTS-1:0]               valid_d;
   logic [N_PORTS-1:0]               overrun_q;
   logic [N_PORTS-1:0]               overrun_d;
   logic [DW-1:0]                    rd_data;
   logic                             unused_addr_bits;

   assign sel              = bus.addr[7:2];
   assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};
   assign status_wr        = bus.write_io_enable && (sel == STATUS_SEL);

   // Address decode for the three data ports
   always_comb begin
      port_sel = '0;
      port_wr  = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
         port_sel[i] = (sel == SEL_BASE + SEL_W'(i));
         port_wr[i]  = bus.write_io_enable && port_sel[i];
      end
   end

   // A write re-arms valid even when acked in the same cycle; the ack retires the old word
   always_comb begin
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (status_wr) begin
         overrun_d = overrun_q & ~bus.datain[5:3];
      end
      for (int i = 0; i < int'(N_PORTS); i++) begin
         if (port_wr[i]) begin
            valid_d[i] = 1'b1;
            if (valid_q[i] && !bus.out_ack[i]) begin
               overrun_d[i] = 1'b1;
            end
         end else if (bus.out_ack[i]) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         port_q    <= {N_PORTS{RST_VAL}};
         valid_q   <= '0;
         overrun_q <= '0;
      end else begin
         for (int i = 0; i < int'(N_PORTS); i++) begin
            if (port_wr[i]) begin
               port_q[i] <= bus.datain;
            end
         end
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // Readback reflects register contents, never the in-flight store data
   always_comb begin
      rd_data = '0;
      if (sel == STATUS_SEL) begin
         rd_data = {STAT_PAD'(0), overrun_q, valid_q};
      end else begin
         for (int i = 0; i < int'(N_PORTS); i++) begin
            if (port_sel[i]) begin
               rd_data = port_q[i];
            end
         end
      end
   end

   assign bus.io_read_data = rd_data;
   assign bus.out_port0    = port_q[0];
   assign bus.out_port1    = port_q[1];
   assign bus.out_port2    = port_q[2];
   assign bus.out_valid    = valid_q;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_io_output_reg.sv
// Directed, table-driven bench for io_output_reg: readback before each edge,
// port/flag state after it, plus hand sequences for reset timing.
module tb_io_output_reg;
   logic io_clk;
   logic reset;

   io_output_reg_if bus_if ();

   io_output_reg #(
      .SEL_BASE (6'b100000),
      .RST_VAL  (32'h0000_0000)
   ) dut (
      .io_clk (io_clk),
      .reset  (reset),
      .bus    (bus_if)
   );

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      logic [2:0]  ack;
      logic [31:0] exp_rd;
      logic [31:0] exp_p0;
      logic [31:0] exp_p1;
      logic [31:0] exp_p2;
      logic [2:0]  exp_v;
      logic [2:0]  exp_o;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [2:0] ack, input logic [31:0] rd,
                      input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [2:0] v, input logic [2:0] o);
      vec_t t;
      t.addr = a; t.data = d; t.we = we; t.ack = ack; t.exp_rd = rd;
      t.exp_p0 = p0; t.exp_p1 = p1; t.exp_p2 = p2; t.exp_v = v; t.exp_o = o;
      vecs.push_back(t);
   endtask

   task automatic check_state(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [2:0] v, input logic [2:0] o);
      check({tag, ".port0"},   bus_if.out_port0, p0);
      check({tag, ".port1"},   bus_if.out_port1, p1);
      check({tag, ".port2"},   bus_if.out_port2, p2);
      check({tag, ".valid"},   32'(bus_if.out_valid), 32'(v));
      check({tag, ".overrun"}, 32'(bus_if.overrun), 32'(o));
   endtask

   initial begin
      //  addr           data           we    ack     rd_pre         p0             p1       p2       v       o
      add(32'h80,        32'hDEAD_BEEF, 1'b1, 3'b000, 32'h0,         32'hDEAD_BEEF, 32'h0,   32'h0,   3'b001, 3'b000);
      add(32'h80,        32'h0,         1'b0, 3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,   32'h0,   3'b000, 3'b000);
      add(32'h8C,        32'h0,         1'b0, 3'b001, 32'h0,         32'hDEAD_BEEF, 32'h0,   32'h0,   3'b000, 3'b000);
      add(32'h84,        32'h1,         1'b1, 3'b000, 32'h0,         32'hDEAD_BEEF, 32'h1,   32'h0,   3'b010, 3'b000);
      add(32'h84,        32'h2,         1'b1, 3'b000, 32'h1,         32'hDEAD_BEEF, 32'h2,   32'h0,   3'b010, 3'b010);
      add(32'h8C,        32'h0,         1'b0, 3'b000, 32'h12,        32'hDEAD_BEEF, 32'h2,   32'h0,   3'b010, 3'b010);
      add(32'h88,        32'hAA,        1'b1, 3'b000, 32'h0,         32'hDEAD_BEEF, 32'h2,   32'hAA,  3'b110, 3'b010);
      add(32'h88,        32'h55,        1'b1, 3'b100, 32'hAA,        32'hDEAD_BEEF, 32'h2,   32'h55,  3'b110, 3'b010);
      add(32'h8C,        32'h10,        1'b1, 3'b000, 32'h16,        32'hDEAD_BEEF, 32'h2,   32'h55,  3'b110, 3'b000);
      add(32'h80,        32'h77,        1'b1, 3'b000, 32'hDEAD_BEEF, 32'h77,        32'h2,   32'h55,  3'b111, 3'b000);
      add(32'hFFFF_FF80, 32'h99,        1'b1, 3'b000, 32'h77,        32'h99,        32'h2,   32'h55,  3'b111, 3'b001);
      add(32'h88,        32'h3,         1'b1, 3'b000, 32'h55,        32'h99,        32'h2,   32'h3,   3'b111, 3'b101);
      add(32'h8C,        32'h38,        1'b1, 3'b000, 32'h2F,        32'h99,        32'h2,   32'h3,   3'b111, 3'b000);
      add(32'h90,        32'hFFFF_FFFF, 1'b1, 3'b000, 32'h0,         32'h99,        32'h2,   32'h3,   3'b111, 3'b000);
      add(32'h7C,        32'h1234,      1'b1, 3'b000, 32'h0,         32'h99,        32'h2,   32'h3,   3'b111, 3'b000);
      add(32'h8C,        32'h7,         1'b1, 3'b000, 32'h07,        32'h99,        32'h2,   32'h3,   3'b111, 3'b000);
      add(32'h84,        32'h0,         1'b0, 3'b111, 32'h2,         32'h99,        32'h2,   32'h3,   3'b000, 3'b000);
      add(32'h84,        32'h5,         1'b1, 3'b010, 32'h2,         32'h99,        32'h5,   32'h3,   3'b010, 3'b000);

      bus_if.addr            = '0;
      bus_if.datain          = '0;
      bus_if.write_io_enable = 1'b0;
      bus_if.out_ack         = '0;
      reset                  = 1'b1;
      repeat (2) @(posedge io_clk);
      #1;
      check_state("reset", 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      reset = 1'b0;

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         bus_if.addr            = vecs[k].addr;
         bus_if.datain          = vecs[k].data;
         bus_if.write_io_enable = vecs[k].we;
         bus_if.out_ack         = vecs[k].ack;
         #1;
         check({tag, ".rd"}, bus_if.io_read_data, vecs[k].exp_rd);
         @(posedge io_clk);
         #1;
         check_state(tag, vecs[k].exp_p0, vecs[k].exp_p1, vecs[k].exp_p2,
                     vecs[k].exp_v, vecs[k].exp_o);
      end
      bus_if.write_io_enable = 1'b0;
      bus_if.out_ack         = '0;

      // Build up overrun, then reset between edges: state must drop without a clock
      bus_if.addr = 32'h84; bus_if.datain = 32'hCAFE; bus_if.write_io_enable = 1'b1;
      @(posedge io_clk); #1;
      bus_if.write_io_enable = 1'b0;
      check_state("pre_rst", 32'h99, 32'hCAFE, 32'h3, 3'b010, 3'b010);
      #2;
      reset = 1'b1;
      #1;
      check_state("async_rst", 32'h0, 32'h0, 32'h0, 3'b000, 3'b000);
      bus_if.addr = 32'h8C;
      #1;
      check("async_rst.status_rd", bus_if.io_read_data, 32'h0);
      @(negedge io_clk);
      reset = 1'b0;

      // Store after release lands on port 0 one edge later
      bus_if.addr = 32'h80; bus_if.datain = 32'hDEAD_BEEF; bus_if.write_io_enable = 1'b1;
      @(posedge io_clk); #1;
      bus_if.write_io_enable = 1'b0;
      check_state("post_rst", 32'hDEAD_BEEF, 32'h0, 32'h0, 3'b001, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end
endmodule
